multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control unit for the multicycle RV32I core. It sequences the shared datapath:
//  one memory port, one ALU and the IR/PC/result registers. A Moore FSM steps through
//  fetch/decode/execute, and side decoders produce ImmSrc and ALUControl. Memory-access
//  states stall on a MemReady handshake so the core can sit behind slow or shared memory.
// PARAMETERS
//  TRAP_EN  1  1: an unsupported opcode enters TRAP and stays there until reset.
//              0: an unsupported opcode returns to FETCH (executes as a NOP).
// PORTS
//  clk         in   1  core clock; all state changes on its rising edge
//  reset       in   1  asynchronous, active-low; state <= FETCH immediately on assertion
//  op          in   7  instr[6:0], taken from the IR
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  Zero        in   1  ALU zero flag
//  MemReady    in   1  memory has completed the current access this cycle
//  PCWrite     out  1  (Branch & Zero) | PCUpdate
//  AdrSrc      out  1  0: memory address = PC; 1: memory address = Result
//  MemWrite    out  1  memory write strobe
//  IRWrite     out  1  load IR and OldPC
//  RegWrite    out  1  register-file write enable
//  ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA     out  2  00 PC, 01 OldPC, 10 RD1
//  ALUSrcB     out  2  00 WriteData, 01 ImmExt, 10 constant 4
//  ImmSrc      out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type (decoded from op)
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  Trap        out  1  high while in TRAP
// BEHAVIOUR
//  States and non-zero outputs (any output not listed is 0):
//   FETCH    AdrSrc=0 ALUSrcB=10 ResultSrc=10 ALUOp=00; IRWrite=PCUpdate=MemReady.
//            Stays in FETCH while MemReady=0, so the PC advances exactly once per fetch.
//   DECODE   ALUSrcA=01 ALUSrcB=01 ALUOp=00 (branch target computed into ALUOut).
//   MEMADR   ALUSrcA=10 ALUSrcB=01 ALUOp=00.
//   MEMREAD  AdrSrc=1. Stays here while MemReady=0.
//   MEMWRITE AdrSrc=1 MemWrite=1. MemWrite is held high until MemReady=1.
//   MEMWB    ResultSrc=01 RegWrite=1.
//   EXECUTER ALUSrcA=10 ALUSrcB=00 ALUOp=10.
//   EXECUTEI ALUSrcA=10 ALUSrcB=01 ALUOp=10.
//   ALUWB    RegWrite=1 (ResultSrc=00).
//   BEQ      ALUSrcA=10 ALUSrcB=00 ALUOp=01 Branch=1.
//   JAL      ALUSrcA=01 ALUSrcB=10 PCUpdate=1.
//   TRAP     Trap=1; every write enable is 0.
//  Transitions:
//   FETCH->DECODE when MemReady=1.
//   DECODE by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI;
//     1100011 -> BEQ; 1101111 -> JAL; any other op -> TRAP (or FETCH when TRAP_EN=0).
//   MEMADR -> MEMREAD if op[5]=0, otherwise MEMWRITE.
//   MEMREAD -> MEMWB when MemReady=1. MEMWRITE -> FETCH when MemReady=1.
//   EXECUTER, EXECUTEI and JAL -> ALUWB. MEMWB, ALUWB and BEQ -> FETCH.
//  Cycles per instruction with zero wait states: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
//   Each MemReady=0 cycle adds 1 cycle to that count.
//  ALU decoder:
//   ALUOp=00 -> add; ALUOp=01 -> sub.
//   ALUOp=10 by funct3: 000 -> sub if (op[5] & funct7b5), else add; 010 -> slt;
//     110 -> or; 111 -> and; any other funct3 -> add (never X).
//  ImmSrc is decoded from op in every state. Unknown op -> 00.
//  Reset mid-instruction aborts the instruction: outputs take FETCH values combinationally,
//   and a pending MemWrite drops in the same cycle reset asserts.
//  State register uses binary encoding. Outputs are decoded combinationally from state
//   and the input fields; the FSM never enters an unlisted state (default -> FETCH).
// STRUCTURE
//  Shared package/header riscv_ctrl_defs.vh holds:
//   opcode constants; state encodings (4 bits); ALUOp, ResultSrc and ALUControl codes.
//  One sub-module, alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl), reused by
//   the single-cycle core. The FSM and ImmSrc decode stay in this file.
// TESTING
//  1 Reset low for 2 cycles, then high with MemReady=1 -> state FETCH, IRWrite=1,
//    PCWrite=1, MemWrite=0, Trap=0.
//  2 op=0010011 (addi x2,x0,5 = 0x00500113) -> FETCH, DECODE, EXECUTEI, ALUWB, FETCH;
//    RegWrite=1 only in ALUWB; ALUControl=000; ImmSrc=00.
//  3 sw (0x0471AA23) with MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for
//    4 consecutive cycles, exactly one MEMWRITE exit, then FETCH.
//  4 beq (op=1100011): Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; ALUControl=001.
//  5 add/sub R-type (0x002081B3, then funct7b5=1) -> ALUControl 000 then 001 in EXECUTER.
//  6 op=1111111 -> TRAP with Trap=1 and no write enables for 10 cycles (TRAP_EN=1);
//    FETCH with TRAP_EN=0; assert reset while in MEMWRITE -> MemWrite=0 at once, FETCH.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared control encodings for the multicycle RV32I controller.
// Opcodes, FSM states, ALUOp, ResultSrc, operand-select and ALUControl codes.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode from ALUOp and instruction fields.
// Shared with the single-cycle core; unlisted funct3 falls back to add.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core.
// Moore outputs from state; memory states stall on MemReady.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit TRAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Trap
);

    state_t     state;
    state_t     next;
    logic [1:0] aluop;
    logic       branch;
    logic       pcupdate;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next;
    end

    always_comb begin
        next      = state;
        aluop     = ALUOP_ADD;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_WD;
        Trap      = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // IR load and PC+4 both gate on MemReady so a stalled fetch advances PC once
                IRWrite   = MemReady;
                pcupdate  = MemReady;
                if (MemReady) next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next = S_MEMADR;
                    OP_RTYPE:          next = S_EXECUTER;
                    OP_ITYPE:          next = S_EXECUTEI;
                    OP_BRANCH:         next = S_BEQ;
                    OP_JAL:            next = S_JAL;
                    default:           next = TRAP_EN ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) next = S_MEMWB;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) next = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                next      = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_WD;
                aluop   = ALUOP_FUNC;
                next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNC;
                next    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                next     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_WD;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                next    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pcupdate = 1'b1;
                next     = S_ALUWB;
            end
            S_TRAP: begin
                Trap = 1'b1;
                next = S_TRAP;
            end
            default: next = S_FETCH;
        endcase
    end

    assign PCWrite = (branch & Zero) | pcupdate;

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_dec (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with an expected-output queue.
// Instantiates TRAP_EN=1 and TRAP_EN=0 copies driven by the same fields.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    logic       PCWrite0, AdrSrc0, MemWrite0, IRWrite0, RegWrite0, Trap0;
    logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ImmSrc0;
    logic [2:0] ALUControl0;

    int cmp_n = 0;
    int err_n = 0;
    logic [20:0] exp_q[$];

    multicycle_controller #(.TRAP_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Trap(Trap)
    );

    multicycle_controller #(.TRAP_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .MemWrite(MemWrite0),
        .IRWrite(IRWrite0), .RegWrite(RegWrite0), .ResultSrc(ResultSrc0),
        .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ImmSrc(ImmSrc0),
        .ALUControl(ALUControl0), .Trap(Trap0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {dut.state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap};
    endfunction

    // Expected outputs per state, taken from the state/output table
    function automatic logic [20:0] mk(state_t s, logic mr, logic z,
                                       logic [2:0] ac, logic [1:0] im);
        logic pcw, adr, mw, irw, rw, tr;
        logic [1:0] rs, sa, sb;
        logic [2:0] a;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; tr = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; a = 3'b000;
        case (s)
            S_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  adr = 1;
            S_MEMWRITE: begin adr = 1; mw = 1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1; end
            S_EXECUTER: begin sa = 2'b10; sb = 2'b00; a = ac; end
            S_EXECUTEI: begin sa = 2'b10; sb = 2'b01; a = ac; end
            S_ALUWB:    rw = 1;
            S_BEQ:      begin sa = 2'b10; a = 3'b001; pcw = z; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            S_TRAP:     tr = 1;
            default:    ;
        endcase
        return {s, pcw, adr, mw, irw, rw, rs, sa, sb, im, a, tr};
    endfunction

    task automatic sample(input string tag, input state_t s,
                          input logic [2:0] ac, input logic [1:0] im);
        logic [20:0] e;
        logic [20:0] g;
        exp_q.push_back(mk(s, MemReady, Zero, ac, im));
        g = obs();
        e = exp_q.pop_front();
        cmp_n++;
        assert (g === e) else begin
            err_n++;
            $error("FAIL %s observed=%h expected=%h", tag, g, e);
        end
    endtask

    task automatic step(input string tag, input state_t s,
                        input logic [2:0] ac, input logic [1:0] im);
        @(negedge clk);
        sample(tag, s, ac, im);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state0(input string tag, input state_t s);
        cmp_n++;
        assert (dut0.state === s) else begin
            err_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dut0.state, s);
        end
    endtask

    task automatic set_instr(input logic [31:0] ins);
        op       = ins[6:0];
        funct3   = ins[14:12];
        funct7b5 = ins[30];
    endtask

    initial begin
        reset    = 1'b0;
        MemReady = 1'b1;
        Zero     = 1'b0;
        set_instr(32'h00500113);
        @(posedge clk);
        #1;
        step("rst_a", S_FETCH, 3'b000, 2'b00);
        step("rst_b", S_FETCH, 3'b000, 2'b00);
        reset = 1'b1;

        // addi with one fetch wait state
        MemReady = 1'b0;
        step("fetch_wait", S_FETCH, 3'b000, 2'b00);
        MemReady = 1'b1;
        step("fetch_addi", S_FETCH, 3'b000, 2'b00);
        step("dec_addi", S_DECODE, 3'b000, 2'b00);
        step("exe_addi", S_EXECUTEI, 3'b000, 2'b00);
        step("wb_addi", S_ALUWB, 3'b000, 2'b00);

        // sw with three MemReady-low cycles
        set_instr(32'h0471AA23);
        step("fetch_sw", S_FETCH, 3'b000, 2'b01);
        step("dec_sw", S_DECODE, 3'b000, 2'b01);
        step("adr_sw", S_MEMADR, 3'b000, 2'b01);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) step("mw_wait", S_MEMWRITE, 3'b000, 2'b01);
        MemReady = 1'b1;
        step("mw_done", S_MEMWRITE, 3'b000, 2'b01);

        // lw with one read wait state
        set_instr(32'h00412183);
        step("fetch_lw", S_FETCH, 3'b000, 2'b00);
        step("dec_lw", S_DECODE, 3'b000, 2'b00);
        step("adr_lw", S_MEMADR, 3'b000, 2'b00);
        MemReady = 1'b0;
        step("mr_wait", S_MEMREAD, 3'b000, 2'b00);
        MemReady = 1'b1;
        step("mr_done", S_MEMREAD, 3'b000, 2'b00);
        step("wb_lw", S_MEMWB, 3'b000, 2'b00);

        // beq taken, then not taken
        set_instr(32'h00208463);
        Zero = 1'b1;
        step("fetch_beq1", S_FETCH, 3'b000, 2'b10);
        step("dec_beq1", S_DECODE, 3'b000, 2'b10);
        step("beq_taken", S_BEQ, 3'b001, 2'b10);
        Zero = 1'b0;
        step("fetch_beq0", S_FETCH, 3'b000, 2'b10);
        step("dec_beq0", S_DECODE, 3'b000, 2'b10);
        step("beq_not", S_BEQ, 3'b001, 2'b10);

        // add then sub
        set_instr(32'h002081B3);
        step("fetch_add", S_FETCH, 3'b000, 2'b00);
        step("dec_add", S_DECODE, 3'b000, 2'b00);
        step("exe_add", S_EXECUTER, 3'b000, 2'b00);
        step("wb_add", S_ALUWB, 3'b000, 2'b00);
        set_instr(32'h402081B3);
        step("fetch_sub", S_FETCH, 3'b000, 2'b00);
        step("dec_sub", S_DECODE, 3'b000, 2'b00);
        step("exe_sub", S_EXECUTER, 3'b001, 2'b00);
        step("wb_sub", S_ALUWB, 3'b000, 2'b00);

        // ori, slti, slli (funct3 001 falls back to add)
        set_instr(32'h00116113);
        step("fetch_ori", S_FETCH, 3'b000, 2'b00);
        step("dec_ori", S_DECODE, 3'b000, 2'b00);
        step("exe_ori", S_EXECUTEI, 3'b011, 2'b00);
        step("wb_ori", S_ALUWB, 3'b000, 2'b00);
        set_instr(32'h00112113);
        step("fetch_slti", S_FETCH, 3'b000, 2'b00);
        step("dec_slti", S_DECODE, 3'b000, 2'b00);
        step("exe_slti", S_EXECUTEI, 3'b101, 2'b00);
        step("wb_slti", S_ALUWB, 3'b000, 2'b00);
        set_instr(32'h00111113);
        step("fetch_slli", S_FETCH, 3'b000, 2'b00);
        step("dec_slli", S_DECODE, 3'b000, 2'b00);
        step("exe_slli", S_EXECUTEI, 3'b000, 2'b00);
        step("wb_slli", S_ALUWB, 3'b000, 2'b00);

        // jal
        set_instr(32'h008000EF);
        step("fetch_jal", S_FETCH, 3'b000, 2'b11);
        step("dec_jal", S_DECODE, 3'b000, 2'b11);
        step("jal", S_JAL, 3'b000, 2'b11);
        step("wb_jal", S_ALUWB, 3'b000, 2'b11);

        // unsupported opcode
        set_instr(32'h0000007F);
        step("fetch_bad", S_FETCH, 3'b000, 2'b00);
        step("dec_bad", S_DECODE, 3'b000, 2'b00);
        chk_state0("notrap_fetch", S_FETCH);
        for (int i = 0; i < 10; i++) step("trap", S_TRAP, 3'b000, 2'b00);
        reset = 1'b0;
        #1;
        sample("trap_rst", S_FETCH, 3'b000, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // reset while a store is stalled
        set_instr(32'h0471AA23);
        step("fetch_sw2", S_FETCH, 3'b000, 2'b01);
        step("dec_sw2", S_DECODE, 3'b000, 2'b01);
        step("adr_sw2", S_MEMADR, 3'b000, 2'b01);
        MemReady = 1'b0;
        #2;
        sample("mw_pre_rst", S_MEMWRITE, 3'b000, 2'b01);
        reset = 1'b0;
        #1;
        sample("mw_rst", S_FETCH, 3'b000, 2'b01);
        chk_state0("mw_rst0", S_FETCH);
        step("rst_hold", S_FETCH, 3'b000, 2'b01);
        reset = 1'b1;
        MemReady = 1'b1;
        step("fetch_final", S_FETCH, 3'b000, 2'b01);
        step("dec_final", S_DECODE, 3'b000, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
